// File: rtl/one_port_ram_ctrl_if.sv
// one_port_ram_ctrl_if: request stream and read-response port between the datapath and the RAM controller.
interface one_port_ram_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rd_valid, rd_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/one_port_ram_ctrl.sv
// one_port_ram_ctrl: clears a single-port synchronous RAM to FILL_VALUE, then serves one read/write per cycle.
module one_port_ram_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  init,
    output logic                  busy,
    one_port_ram_ctrl_if.slave    bus,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);
    typedef enum logic [1:0] {START, CLEAR, IDLE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  rd_p1_q, rd_p1_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  ready;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy      = 1'b1;
        ready     = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = bus.req_addr;
        ram_d     = bus.req_wdata;
        case (state_q)
            START: begin
                state_d   = CLEAR;
                clr_cnt_d = '0;
            end
            CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = clr_cnt_q;
                ram_d     = FILL_VALUE;
                clr_cnt_d = clr_cnt_q + 1'b1;
                state_d   = (clr_cnt_q == '1) ? IDLE : CLEAR;
            end
            default: begin
                busy      = 1'b0;
                ready     = !init;
                ram_we    = !init && bus.req_valid && bus.req_we;
                state_d   = init ? CLEAR : IDLE;
                clr_cnt_d = '0;
            end
        endcase
        rd_p1_d = ready && bus.req_valid && !bus.req_we;
    end

    // RAM q already reflects the address registered on the accepting edge, so capture it one edge later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= START;
            clr_cnt_q  <= '0;
            rd_p1_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_p1_q    <= rd_p1_d;
            rd_valid_q <= rd_p1_q;
            rd_data_q  <= rd_p1_q ? ram_q : rd_data_q;
        end
    end

    assign bus.req_ready = ready;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_one_port_ram_ctrl.sv
// tb_one_port_ram_ctrl: random and directed traffic against a behavioural RAM, scored by a decoupled read monitor.
module tb_one_port_ram_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] FILL = 8'hA5;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          init = 1'b0;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] addr_r = '0;
    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          sb[$];
    int            clear_left = 0;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    one_port_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    one_port_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FILL_VALUE(FILL)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .busy(busy), .bus(bus),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered write, registered read address.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        addr_r <= ram_addr;
    end
    assign ram_q = mem[addr_r];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_data %0h expected no response", bus.rd_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", bus.rd_data, e.d);
                check("rd_latency", cyc, e.c + 2);
            end
        end
    end

    task automatic fill_ref();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
    endtask

    task automatic drive(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit in);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        init          = in;
    endtask

    // One request cycle: drive after the edge, score against the model at the negedge.
    task automatic do_req(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit in);
        bit exp_ready;
        @(posedge clk);
        #1 drive(v, we, a, d, in);
        @(negedge clk);
        exp_ready = (clear_left == 0) && !in;
        check("busy", busy, clear_left != 0);
        check("req_ready", bus.req_ready, exp_ready);
        if (in && clear_left == 0) begin
            fill_ref();
            clear_left = DEPTH;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (v && exp_ready) begin
            if (we) ref_mem[a] = d;
            else sb.push_back('{ref_mem[a], cyc});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_req(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic count_busy(input int exp, input string name);
        int n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, n, exp);
        check({name, "_ready_after"}, bus.req_ready, 1'b1);
        clear_left = 0;
    endtask

    task automatic end_clear_cycle();
        @(posedge clk);
        #1 drive(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) do_req(1'b0, 1'b0, AW'(i), '0, 1'b0);
        idle(3);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_ready"}, bus.req_ready, 1'b0);
        check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
        check({tag, "_rd_data"}, bus.rd_data, '0);
        check({tag, "_ram_we"}, ram_we, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        fill_ref();
        count_busy(DEPTH + 1, "reset_busy_len");
        read_all();

        do_req(1'b1, 1'b1, 4'd3, 8'h3C, 1'b0);
        do_req(1'b1, 1'b0, 4'd3, '0, 1'b0);
        idle(3);

        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 1'b1, AW'(i), DW'(i) ^ 8'hFF, 1'b0);
        read_all();

        do_req(1'b1, 1'b1, 4'd5, 8'h11, 1'b1);
        end_clear_cycle();
        count_busy(DEPTH, "init_busy_len");
        do_req(1'b1, 1'b0, 4'd5, '0, 1'b0);
        idle(3);

        do_req(1'b1, 1'b1, 4'd7, 8'h42, 1'b0);
        do_req(1'b1, 1'b0, 4'd7, '0, 1'b0);
        do_req(1'b0, 1'b0, '0, '0, 1'b1);
        end_clear_cycle();
        count_busy(DEPTH, "init_rd_busy_len");
        read_all();

        do_req(1'b0, 1'b0, '0, '0, 1'b1);
        end_clear_cycle();
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_values("midclr");
        @(posedge clk);
        #1 reset_n = 1'b1;
        fill_ref();
        clear_left = 0;
        count_busy(DEPTH + 1, "midclr_busy_len");
        read_all();

        for (int i = 0; i < 400; i++)
            do_req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, AW'($urandom),
                   DW'($urandom), $urandom_range(0, 59) == 0);
        idle(DEPTH + 4);
        read_all();
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
